// File: rtl/egress_sched_pkg.sv
// ---------------------------------------------------------------------------
// egress_sched_pkg
// Shared definitions for the egress scheduling blocks.
//   ARB_IDLE_S / ARB_SEND_S : arbiter state encoding
//   MAX_QUEUES              : largest supported number of traffic-class queues
//   GRANT_W                 : width of a queue / grant index
// ---------------------------------------------------------------------------
package egress_sched_pkg;

  localparam int MAX_QUEUES = 8;
  localparam int GRANT_W    = 3;

  typedef enum logic [0:0] {
    ARB_IDLE_S = 1'b0,
    ARB_SEND_S = 1'b1
  } arb_state_e;

endpackage

// File: rtl/egress_priority_arbiter_prio_select.sv
// ---------------------------------------------------------------------------
// prio_select
// Combinational highest-set-index finder.
//   req   : N-bit request vector (N <= MAX_QUEUES)
//   idx   : index of the highest set bit of req (0 when none set)
//   valid : 1 when any bit of req is set
// ---------------------------------------------------------------------------
module prio_select
  import egress_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]       req,
  output logic [GRANT_W-1:0] idx,
  output logic               valid
);

  // Ascending scan: the last set bit visited is the highest one.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx   = i[GRANT_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/egress_priority_arbiter.sv
// ---------------------------------------------------------------------------
// egress_priority_arbiter
// Strict-priority, frame-granular arbiter sharing one egress AXI-Stream
// datapath between C_NUM_QUEUES traffic-class queues. A granted frame is
// never preempted; the highest eligible queue index wins at each arbitration.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   s_axis_*                 : flattened per-queue AXI-Stream inputs
//   gate_open                : per-queue permission to start a frame
//   m_axis_*                 : shared AXI-Stream output (granted queue's beat)
//   grant_idx                : queue currently (or last) granted
//   busy                     : high while a frame is being forwarded
//   frame_cnt                : flattened per-queue completed-frame counters
// ---------------------------------------------------------------------------
module egress_priority_arbiter
  import egress_sched_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 128,
  parameter int C_NUM_QUEUES  = 4,
  parameter int C_CNT_WIDTH   = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [C_NUM_QUEUES*C_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [C_NUM_QUEUES*C_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [C_NUM_QUEUES*C_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_NUM_QUEUES-1:0]               s_axis_tvalid,
  input  logic [C_NUM_QUEUES-1:0]               s_axis_tlast,
  output logic [C_NUM_QUEUES-1:0]               s_axis_tready,
  input  logic [C_NUM_QUEUES-1:0]               gate_open,
  output logic [C_DATA_WIDTH-1:0]               m_axis_tdata,
  output logic [C_TUSER_WIDTH-1:0]              m_axis_tuser,
  output logic [C_DATA_WIDTH/8-1:0]             m_axis_tkeep,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready,
  output logic [GRANT_W-1:0]                    grant_idx,
  output logic                                  busy,
  output logic [C_NUM_QUEUES*C_CNT_WIDTH-1:0]   frame_cnt
);

  localparam int KEEP_W = C_DATA_WIDTH / 8;

  arb_state_e               state_q, state_d;
  logic [GRANT_W-1:0]       grant_q, grant_d;
  logic [C_CNT_WIDTH-1:0]   frame_cnt_q [C_NUM_QUEUES];
  logic [C_CNT_WIDTH-1:0]   frame_cnt_d [C_NUM_QUEUES];

  logic [C_NUM_QUEUES-1:0]  eligible;
  logic [C_NUM_QUEUES-1:0]  grant_onehot;
  logic [GRANT_W-1:0]       sel_idx;
  logic                     sel_valid;
  logic                     frame_done;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  assign eligible = s_axis_tvalid & gate_open;

  prio_select #(
    .N (C_NUM_QUEUES)
  ) u_prio_select (
    .req   (eligible),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  // One-hot decode of the registered grant drives both the datapath mux and
  // the counter enables, so the 3-bit index never indexes past the queues.
  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_QUEUES; gi++) begin : g_onehot
      assign grant_onehot[gi] = (grant_q == GRANT_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE_S;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ARB_IDLE_S: begin
        if (sel_valid) begin
          grant_d = sel_idx;
          state_d = ARB_SEND_S;
        end
      end
      ARB_SEND_S: begin
        // Gates and new arrivals are not looked at here: the frame finishes.
        if (frame_done) begin
          state_d = ARB_IDLE_S;
        end
      end
      default: state_d = ARB_IDLE_S;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs and datapath mux
  // -------------------------------------------------------------------------
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    for (int q = 0; q < C_NUM_QUEUES; q++) begin
      if (grant_onehot[q]) begin
        // Payload follows the grant unconditionally; it only matters when
        // tvalid is asserted, which is restricted to SEND below.
        m_axis_tdata = s_axis_tdata[q*C_DATA_WIDTH +: C_DATA_WIDTH];
        m_axis_tuser = s_axis_tuser[q*C_TUSER_WIDTH +: C_TUSER_WIDTH];
        m_axis_tkeep = s_axis_tkeep[q*KEEP_W +: KEEP_W];
        if (state_q == ARB_SEND_S) begin
          m_axis_tvalid    = s_axis_tvalid[q];
          m_axis_tlast     = s_axis_tlast[q];
          s_axis_tready[q] = m_axis_tready;
        end
      end
    end
  end

  assign busy       = (state_q == ARB_SEND_S);
  assign grant_idx  = grant_q;
  assign frame_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // -------------------------------------------------------------------------
  // Per-queue completed-frame counters (wrap naturally)
  // -------------------------------------------------------------------------
  always_comb begin
    for (int q = 0; q < C_NUM_QUEUES; q++) begin
      frame_cnt_d[q] = frame_cnt_q[q];
      if (frame_done && grant_onehot[q]) begin
        frame_cnt_d[q] = frame_cnt_q[q] + C_CNT_WIDTH'(1);
      end
    end
  end

  generate
    for (gi = 0; gi < C_NUM_QUEUES; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          frame_cnt_q[gi] <= '0;
        end else begin
          frame_cnt_q[gi] <= frame_cnt_d[gi];
        end
      end
      assign frame_cnt[gi*C_CNT_WIDTH +: C_CNT_WIDTH] = frame_cnt_q[gi];
    end
  endgenerate

endmodule
